fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 19-bit pipelined CPU. It tracks destination-register records for the instructions in EX and MEM and produces the 2-bit select codes consumed by the ALU operand forwarding muxes, one per operand. It also raises a one-cycle stall when the instruction in ID depends on a load currently in EX. It sits between the ID stage decoder and the ID/EX pipeline register, and produces its selects for the instruction entering EX.

---
 rtl/fwd_hazard_if.sv | 30 +++
 rtl/fwd_hazard_ctrl.sv | 78 +++++++
 tb/tb_fwd_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_if.sv
// ID-stage request and forwarding/stall response bundle for fwd_hazard_ctrl.
// The decoder side uses master; the controller uses slave.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_is_load;
  logic              flush;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load, flush,
    input  sel_a, sel_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load, flush,
    output sel_a, sel_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select and load-use stall generation for the instruction entering EX.
// Tracks EX and MEM destination records; selects are registered, stall is combinational.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  fwd_hazard_if.slave  bus
);

  // MEM needs no load flag: MEM/WB forwarding already carries load data.
  logic              ex_v_q, ex_v_d;
  logic              ex_ld_q, ex_ld_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              mem_v_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic match_ex1, match_ex2, match_mem1, match_mem2;
  logic stall, load_ex;

  always_comb begin
    match_ex1  = bus.id_rs1_used & ex_v_q  & (ex_rd_q  == bus.id_rs1) & (bus.id_rs1 != '0);
    match_ex2  = bus.id_rs2_used & ex_v_q  & (ex_rd_q  == bus.id_rs2) & (bus.id_rs2 != '0);
    match_mem1 = bus.id_rs1_used & mem_v_q & (mem_rd_q == bus.id_rs1) & (bus.id_rs1 != '0);
    match_mem2 = bus.id_rs2_used & mem_v_q & (mem_rd_q == bus.id_rs2) & (bus.id_rs2 != '0);
    stall      = bus.id_valid & ~bus.flush & (match_ex1 | match_ex2) & ex_ld_q;
    load_ex    = bus.id_valid & ~stall & ~bus.flush;
  end

  always_comb begin
    ex_v_d  = load_ex & bus.id_we & (bus.id_rd != '0);
    ex_ld_d = load_ex & bus.id_is_load;
    ex_rd_d = bus.id_rd;
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (load_ex) begin
      // Newest producer wins: EX record before MEM record.
      if (match_ex1)       sel_a_d = 2'b01;
      else if (match_mem1) sel_a_d = 2'b10;
      if (match_ex2)       sel_b_d = 2'b01;
      else if (match_mem2) sel_b_d = 2'b10;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q   <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      sel_a_q  <= 2'b00;
      sel_b_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_ld_q  <= ex_ld_d;
      ex_rd_q  <= ex_rd_d;
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.sel_a     = sel_a_q;
  assign bus.sel_b     = sel_b_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a pipeline-slot reference model predicts each cycle's
// stall and registered outputs; a negedge monitor compares them against the DUT.
module tb_fwd_hazard_ctrl;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       we;
    bit       ld;
    bit [2:0] rs1;
    bit       u1;
    bit [2:0] rs2;
    bit       u2;
  } instr_t;

  typedef struct packed {
    logic             stall;
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model: contents of the EX and MEM pipeline slots plus visible outputs.
  instr_t m_ex, m_mem;
  int     m_sa, m_sb, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(bit [2:0] rd, bit we, bit ld, bit [2:0] rs1, bit u1,
                                bit [2:0] rs2, bit u2);
    instr_t i;
    i.v = 1'b1; i.rd = rd; i.we = we; i.ld = ld;
    i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    return i;
  endfunction

  function automatic instr_t idle();
    instr_t i;
    i = mk(0, 0, 0, 0, 0, 0, 0);
    i.v = 1'b0;
    return i;
  endfunction

  function automatic bit produces(instr_t s, bit [2:0] r);
    return s.v && s.we && (s.rd == r) && (r != 0);
  endfunction

  function automatic int src_for(bit used, bit [2:0] r);
    if (!used)              return 0;
    if (produces(m_ex, r))  return 1;
    if (produces(m_mem, r)) return 2;
    return 0;
  endfunction

  task automatic drive(input instr_t in, input bit fl);
    bus.id_valid    = in.v;
    bus.id_rd       = in.rd;
    bus.id_we       = in.we;
    bus.id_is_load  = in.ld;
    bus.id_rs1      = in.rs1;
    bus.id_rs1_used = in.u1;
    bus.id_rs2      = in.rs2;
    bus.id_rs2_used = in.u2;
    bus.flush       = fl;
  endtask

  task automatic model_reset();
    m_ex = idle(); m_mem = idle();
    m_sa = 0; m_sb = 0; m_cnt = 0;
  endtask

  // One pipeline cycle: drive ID, predict this cycle, then advance the model past the edge.
  task automatic step(input instr_t in, input bit fl, output bit st);
    bit enter;
    int nsa, nsb;
    @(posedge clk); #2;
    drive(in, fl);
    st = in.v && !fl && m_ex.ld &&
         ((in.u1 && produces(m_ex, in.rs1)) || (in.u2 && produces(m_ex, in.rs2)));
    sb_q.push_back('{st, m_sa[1:0], m_sb[1:0], m_cnt[CNT_W-1:0]});
    enter = in.v && !st && !fl;
    nsa = enter ? src_for(in.u1, in.rs1) : 0;
    nsb = enter ? src_for(in.u2, in.rs2) : 0;
    m_mem = m_ex;
    m_ex  = enter ? in : idle();
    m_sa  = nsa;
    m_sb  = nsb;
    if (st && m_cnt < CMAX) m_cnt++;
  endtask

  // ID holds a stalled instruction until it is accepted.
  task automatic issue(input instr_t in);
    bit st;
    int n = 0;
    do begin
      step(in, 1'b0, st);
      n++;
    end while (st && n < 4);
    if (st) chk("stall_bound", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    drive(idle(), 1'b0);
    #1;
    chk("rst_sel_a", bus.sel_a, 0);
    chk("rst_sel_b", bus.sel_b, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    model_reset();
    sb_q.push_back('0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_q.push_back('0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall", bus.stall, e.stall);
        chk("sel_a", bus.sel_a, e.sa);
        chk("sel_b", bus.sel_b, e.sb);
        chk("stall_cnt", bus.stall_cnt, e.cnt);
      end
    end
  end

  initial begin : driver
    bit     st;
    bit     fl;
    bit     hold;
    instr_t cur;
    int     w;
    drive(idle(), 1'b0);
    model_reset();
    do_reset();

    // No producers in flight.
    issue(mk(0, 0, 0, 3, 1, 4, 1));
    issue(idle());
    // EX-to-EX forward, then MEM/WB forward across one unrelated instruction.
    issue(mk(2, 1, 0, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 2, 1, 1, 1));
    issue(mk(2, 1, 0, 0, 0, 0, 0));
    issue(mk(7, 1, 0, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 2, 1, 0, 0));
    // Newest producer wins; r0 never forwards.
    issue(mk(5, 1, 0, 0, 0, 0, 0));
    issue(mk(5, 1, 0, 0, 0, 0, 0));
    issue(mk(3, 1, 0, 0, 0, 5, 1));
    issue(mk(0, 1, 0, 0, 0, 0, 0));
    issue(mk(3, 1, 0, 0, 1, 0, 1));
    // Load-use stall.
    issue(mk(6, 1, 1, 0, 0, 0, 0));
    issue(mk(1, 1, 0, 6, 1, 0, 0));
    issue(idle());
    @(negedge clk);
    chk("loaduse_cnt", bus.stall_cnt, 1);
    // Load-use masked by flush.
    issue(mk(6, 1, 1, 0, 0, 0, 0));
    step(mk(1, 1, 0, 6, 1, 0, 0), 1'b1, st);
    issue(idle());
    // Back-to-back loads into one consumer.
    issue(mk(4, 1, 1, 0, 0, 0, 0));
    issue(mk(4, 1, 1, 0, 0, 0, 0));
    issue(mk(2, 1, 0, 0, 0, 4, 1));
    // Saturate the counter.
    for (int i = 0; i < CMAX + 3; i++) begin
      issue(mk(6, 1, 1, 0, 0, 0, 0));
      issue(mk(1, 1, 0, 0, 0, 6, 1));
    end
    issue(idle());
    @(negedge clk);
    chk("sat_cnt", bus.stall_cnt, CMAX);

    hold = 1'b0;
    cur  = idle();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        hold = 1'b0;
      end
      if (!hold) begin
        cur = mk(3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
                 1'($urandom));
        cur.v = ($urandom_range(0, 7) != 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      step(cur, fl, st);
      hold = st;
    end

    w = 0;
    while (sb_q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    chk("drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
